mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 104 ++++++++++
 tb/tb_mem_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bus bundle between the fetch/data requesters and mem_responder.
// The master side is the requester and the slave side is the responder.
interface mem_responder_if;
  logic [11:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_valid;
  logic        i_stall;
  logic        d_req;
  logic        d_write;
  logic [11:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mis_err;

  modport master (
    output i_addr, d_req, d_write, d_addr, d_wdata,
    input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall, mis_err
  );

  modport slave (
    input  i_addr, d_req, d_write, d_addr, d_wdata,
    output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall, mis_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-ported 16-bit word memory shared by a fetch port and a data port.
// The data port has priority, but a fetch slot is forced after MAX_D_STREAK data grants.
module mem_responder #(
  parameter int unsigned DEPTH        = 2048,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = ($clog2(MAX_D_STREAK + 1) > 2) ? $clog2(MAX_D_STREAK + 1) : 2;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    GNT_FETCH,
    GNT_DREAD,
    GNT_DWRITE
  } grant_e;

  grant_e        grant;
  logic [SW-1:0] streak;
  logic [15:0]   mem [DEPTH];

  logic [11:0]   acc_addr;
  logic [AW-1:0] acc_idx;
  logic          misaligned;
  logic [15:0]   rd_word;

  logic [15:0]   i_rdata_q;
  logic [15:0]   d_rdata_q;
  logic          i_valid_q;
  logic          d_valid_q;
  logic          mis_err_q;

  function automatic logic [AW-1:0] word_index(input logic [11:0] addr);
    logic [11:0] w;
    w = {1'b0, addr[11:1]};
    return AW'(w % 12'(DEPTH));
  endfunction

  always_comb begin
    grant = GNT_FETCH;
    if (bus.d_req && (streak < STREAK_MAX)) begin
      grant = bus.d_write ? GNT_DWRITE : GNT_DREAD;
    end
    acc_addr   = (grant == GNT_FETCH) ? bus.i_addr : bus.d_addr;
    acc_idx    = word_index(acc_addr);
    misaligned = acc_addr[0];
    // Array read sees writes from earlier edges, so read-after-write needs no bypass.
    rd_word    = misaligned ? '0 : mem[acc_idx];
  end

  assign bus.i_stall = (grant != GNT_FETCH);
  assign bus.d_stall = bus.d_req && (grant == GNT_FETCH);

  // Array contents deliberately survive reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (rst_n && (grant == GNT_DWRITE) && !misaligned) begin
      mem[acc_idx] <= bus.d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      mis_err_q <= 1'b0;
      streak    <= '0;
    end else begin
      i_valid_q <= (grant == GNT_FETCH);
      d_valid_q <= (grant == GNT_DREAD);
      if (misaligned) begin
        mis_err_q <= 1'b1;
      end
      case (grant)
        GNT_FETCH: begin
          i_rdata_q <= rd_word;
          streak    <= '0;
        end
        GNT_DREAD: begin
          d_rdata_q <= rd_word;
          streak    <= streak + 1'b1;
        end
        GNT_DWRITE: begin
          streak    <= streak + 1'b1;
        end
        default: begin
          streak    <= '0;
        end
      endcase
    end
  end

  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_valid = i_valid_q;
  assign bus.d_valid = d_valid_q;
  assign bus.mis_err = mis_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a cycle-level behavioural model.
// The bench uses a reduced DEPTH so that full 12-bit addresses exercise wrap-around.
module tb_mem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned MAXS  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(.DEPTH(DEPTH), .MAX_D_STREAK(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] mem_m [DEPTH];
  int          streak_m;
  logic        exp_iv, exp_dv, exp_mis;
  logic [15:0] exp_ir, exp_dr;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: drive, check stalls, advance model, check registered outputs.
  task automatic cycle(input logic rstn, input logic [11:0] ia, input logic dreq,
                       input logic dwr, input logic [11:0] da, input logic [15:0] wd,
                       output logic accepted);
    logic        dg;
    logic [11:0] a;
    int unsigned w;
    @(negedge clk);
    rst_n       = rstn;
    bus.i_addr  = ia;
    bus.d_req   = dreq;
    bus.d_write = dwr;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    #1;
    dg = dreq && (streak_m < MAXS);
    check("i_stall", 16'(bus.i_stall), 16'(dg));
    check("d_stall", 16'(bus.d_stall), 16'(dreq && !dg));
    accepted = rstn && dg;
    if (!rstn) begin
      exp_iv = 0; exp_dv = 0; exp_mis = 0; exp_ir = '0; exp_dr = '0; streak_m = 0;
    end else begin
      a = dg ? da : ia;
      w = int'(a >> 1) % DEPTH;
      if (a[0]) exp_mis = 1'b1;
      if (dg) begin
        streak_m++;
        exp_iv = 0;
        exp_dv = !dwr;
        if (dwr) begin
          if (!a[0]) mem_m[w] = wd;
        end else begin
          exp_dr = a[0] ? 16'h0000 : mem_m[w];
        end
      end else begin
        streak_m = 0;
        exp_iv = 1;
        exp_dv = 0;
        exp_ir = a[0] ? 16'h0000 : mem_m[w];
      end
    end
    @(posedge clk);
    #1;
    check("i_valid", 16'(bus.i_valid), 16'(exp_iv));
    check("i_rdata", bus.i_rdata, exp_ir);
    check("d_valid", 16'(bus.d_valid), 16'(exp_dv));
    check("d_rdata", bus.d_rdata, exp_dr);
    check("mis_err", 16'(bus.mis_err), 16'(exp_mis));
  endtask

  // Data access retried until granted; bounded by the forced fetch slot.
  task automatic data_acc(input logic [11:0] ia, input logic dwr,
                          input logic [11:0] da, input logic [15:0] wd);
    logic acc;
    acc = 0;
    for (int t = 0; t < int'(MAXS) + 2 && !acc; t++) begin
      cycle(1'b1, ia, 1'b1, dwr, da, wd, acc);
    end
    if (!acc) check("accept_timeout", 16'd0, 16'd1);
  endtask

  task automatic idle(input logic [11:0] ia);
    logic acc;
    cycle(1'b1, ia, 1'b0, 1'b0, 12'h000, 16'h0000, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [11:0] ra, rd_a;
    logic [15:0] pre020;
    rst_n = 0;
    bus.i_addr = '0; bus.d_req = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    streak_m = 0; exp_iv = 0; exp_dv = 0; exp_mis = 0; exp_ir = '0; exp_dr = '0;

    repeat (3) cycle(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, acc);

    // Preload every word; word 0 first so fetches from 0 never see unknown data.
    data_acc(12'h000, 1'b1, 12'h000, 16'h1111);
    for (int unsigned i = 1; i < DEPTH; i++) begin
      data_acc(12'h000, 1'b1, 12'(i * 2), 16'($urandom));
    end
    data_acc(12'h000, 1'b1, 12'h002, 16'h2222);

    // Fetch-only sequence.
    idle(12'h000);
    check("fetch0", bus.i_rdata, 16'h1111);
    idle(12'h002);
    check("fetch1", bus.i_rdata, 16'h2222);

    // Write then read back-to-back.
    data_acc(12'h000, 1'b1, 12'h010, 16'hBEEF);
    data_acc(12'h000, 1'b0, 12'h010, 16'h0000);
    check("raw_beef", bus.d_rdata, 16'hBEEF);

    // Starvation: five consecutive requests, fourth one loses to a fetch.
    idle(12'h000);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 12'h002, 1'b1, 1'b0, 12'h010, 16'h0000, acc);
      check("starve_grant", 16'(acc), 16'(k != 3));
    end
    check("starve_ivalid", 16'(bus.i_valid), 16'd0);

    // Misaligned write is dropped, misaligned read returns zero.
    idle(12'h000);
    pre020 = mem_m[16];
    data_acc(12'h000, 1'b1, 12'h021, 16'h1234);
    check("mis_set", 16'(bus.mis_err), 16'd1);
    data_acc(12'h000, 1'b0, 12'h020, 16'h0000);
    check("mis_nowrite", bus.d_rdata, pre020);
    data_acc(12'h000, 1'b0, 12'h021, 16'h0000);
    check("mis_read0", bus.d_rdata, 16'h0000);

    // Reset on the read's granting edge discards it; memory survives.
    cycle(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 16'h0000, acc);
    check("rst_dvalid", 16'(bus.d_valid), 16'd0);
    check("rst_drdata", bus.d_rdata, 16'h0000);
    data_acc(12'h000, 1'b0, 12'h010, 16'h0000);
    check("rst_keep", bus.d_rdata, 16'hBEEF);

    // Randomized traffic over the full 12-bit address range.
    for (int n = 0; n < 3000; n++) begin
      ra   = 12'($urandom) & 12'hFFE;
      rd_a = 12'($urandom) & 12'hFFE;
      if ($urandom_range(0, 15) == 0) rd_a[0] = 1'b1;
      if ($urandom_range(0, 31) == 0) ra[0] = 1'b1;
      cycle(($urandom_range(0, 99) != 0), ra, ($urandom_range(0, 9) < 6),
            1'($urandom), rd_a, 16'($urandom), acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
